// File: rtl/aes_frame_pkg.sv
// rtl/aes_frame_pkg.sv - shared state encoding and command constants for the AES frame controller
package aes_frame_pkg;

    localparam int FRAME_BYTES = 16;

    localparam logic [7:0] CMD_ENC        = 8'h45;  // 'E'
    localparam logic [7:0] CMD_DEC        = 8'h44;  // 'D'
    localparam logic [7:0] CMD_ENC_CACHED = 8'h65;  // 'e'
    localparam logic [7:0] CMD_DEC_CACHED = 8'h64;  // 'd'

    typedef enum logic [2:0] {
        IDLE,
        RXKEY,
        RXTXT,
        START,
        WAIT,
        TXBYTE,
        TXGAP
    } state_t;

endpackage

// File: rtl/aes_frame_txser.sv
// rtl/aes_frame_txser.sv - AES result capture and MSB-first byte serializer
//
// Ports:
//   i_Clk, i_Rst     clock, synchronous active-low reset
//   i_State          controller state; serializer acts in WAIT and TXBYTE
//   i_AesDone        result strobe from the AES core (used only in WAIT)
//   i_AesText        AES result, captured on i_AesDone in WAIT
//   i_TxBusy         UART transmitter busy; holds the serializer in TXBYTE
//   o_TxData         byte being sent
//   o_TxStart        one-cycle send strobe
//   o_Last           high once all 16 bytes have been sent (index wrapped)
module aes_frame_txser
    import aes_frame_pkg::*;
(
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  state_t       i_State,
    input  logic         i_AesDone,
    input  logic [127:0] i_AesText,
    input  logic         i_TxBusy,
    output logic [7:0]   o_TxData,
    output logic         o_TxStart,
    output logic         o_Last
);

    logic [127:0] shreg;
    logic [3:0]   idx;

    // idx starts at 0 on capture and wraps back to 0 after the 16th byte,
    // so in TXGAP a zero index means the whole block has gone out.
    assign o_Last = (idx == 4'd0);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            shreg     <= '0;
            idx       <= '0;
            o_TxData  <= '0;
            o_TxStart <= 1'b0;
        end else begin
            o_TxStart <= 1'b0;
            if (i_State == WAIT && i_AesDone) begin
                shreg <= i_AesText;
                idx   <= '0;
            end else if (i_State == TXBYTE && !i_TxBusy) begin
                o_TxData  <= shreg[127:120];
                shreg     <= {shreg[119:0], 8'h00};
                o_TxStart <= 1'b1;
                idx       <= idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aes_frame_ctrl.sv
// rtl/aes_frame_ctrl.sv - UART framed command front end for an AES core
//
// Frame: command byte, 16 key bytes, 16 text bytes (first byte -> [127:120]).
// 'E' encrypts, 'D' decrypts; the 16-byte result is sent back MSB byte first.
// Optional feature macro: AES_FRAME_KEY_CACHE_EN adds 'e'/'d' commands that
// skip the key field and reuse the last loaded key.
//
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-low reset
//   i_RxData, i_RxValid     received UART byte and its one-cycle strobe
//   o_TxData, o_TxStart     byte to UART transmitter and its send strobe
//   i_TxBusy                UART transmitter busy
//   o_AesStart, o_AesDec    AES start strobe and direction (1 = decrypt)
//   o_AesKey, o_AesText     AES key and input text
//   i_AesDone, i_AesText    AES completion strobe and result
//   o_Busy                  high whenever not IDLE
//   o_fErr                  one-cycle error pulse (bad command or timeout)
module aes_frame_ctrl
    import aes_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic [7:0]   i_RxData,
    input  logic         i_RxValid,
    output logic [7:0]   o_TxData,
    output logic         o_TxStart,
    input  logic         i_TxBusy,
    output logic         o_AesStart,
    output logic         o_AesDec,
    output logic [127:0] o_AesKey,
    output logic [127:0] o_AesText,
    input  logic         i_AesDone,
    input  logic [127:0] i_AesText,
    output logic         o_Busy,
    output logic         o_fErr
);

    localparam int         TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0] CNT_LAST  = 4'(FRAME_BYTES - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [TW-1:0] tmo;
    logic          tx_last;

    aes_frame_txser u_txser (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_State   (state),
        .i_AesDone (i_AesDone),
        .i_AesText (i_AesText),
        .i_TxBusy  (i_TxBusy),
        .o_TxData  (o_TxData),
        .o_TxStart (o_TxStart),
        .o_Last    (tx_last)
    );

    // o_AesKey doubles as the key cache: it is only overwritten in RXKEY.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo        <= '0;
            o_AesStart <= 1'b0;
            o_AesDec   <= 1'b0;
            o_AesKey   <= '0;
            o_AesText  <= '0;
            o_Busy     <= 1'b0;
            o_fErr     <= 1'b0;
        end else begin
            o_AesStart <= 1'b0;
            o_fErr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_RxValid) begin
                        cnt <= '0;
                        tmo <= '0;
                        if (i_RxData == CMD_ENC || i_RxData == CMD_DEC) begin
                            o_AesDec <= (i_RxData == CMD_DEC);
                            o_Busy   <= 1'b1;
                            state    <= RXKEY;
`ifdef AES_FRAME_KEY_CACHE_EN
                        end else if (i_RxData == CMD_ENC_CACHED || i_RxData == CMD_DEC_CACHED) begin
                            o_AesDec <= (i_RxData == CMD_DEC_CACHED);
                            o_Busy   <= 1'b1;
                            state    <= RXTXT;
`endif
                        end else begin
                            o_fErr <= 1'b1;
                        end
                    end
                end
                RXKEY, RXTXT: begin
                    // An arriving byte wins over a simultaneous timeout expiry.
                    if (i_RxValid) begin
                        tmo <= '0;
                        cnt <= cnt + 4'd1;
                        if (state == RXKEY) begin
                            o_AesKey <= {o_AesKey[119:0], i_RxData};
                            if (cnt == CNT_LAST) begin
                                state <= RXTXT;
                            end
                        end else begin
                            o_AesText <= {o_AesText[119:0], i_RxData};
                            if (cnt == CNT_LAST) begin
                                o_AesStart <= 1'b1;
                                state      <= START;
                            end
                        end
                    end else if (tmo == TMO_LAST) begin
                        o_fErr <= 1'b1;
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_AesDone) begin
                        state <= TXBYTE;
                    end
                end
                TXBYTE: begin
                    if (!i_TxBusy) begin
                        state <= TXGAP;
                    end
                end
                TXGAP: begin
                    if (tx_last) begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= TXBYTE;
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_frame_ctrl.md
AES_FRAME_CTRL -- requirements
Module: aes_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000, the number of idle cycles between received frame bytes before the frame is aborted.
REQ-002 SHALL have ports as follows:
- i_Clk  in  1  clock
- i_Rst  in  1  reset: synchronous, active-low
- i_RxData  in  8  received UART byte
- i_RxValid  in  1  one-cycle strobe; i_RxData valid
- o_TxData  out  8  byte to UART transmitter
- o_TxStart  out  1  one-cycle send strobe
- i_TxBusy  in  1  UART transmitter busy
- o_AesStart  out  1  one-cycle start to AES core
- o_AesDec  out  1  1 = decrypt, 0 = encrypt
- o_AesKey  out  128  key to AES core
- o_AesText  out  128  text to AES core
- i_AesDone  in  1  one-cycle done from AES core
- i_AesText  in  128  AES result; valid only while i_AesDone=1
- o_Busy  out  1  high in every state except IDLE
- o_fErr  out  1  one-cycle error pulse

Function
REQ-003 SHALL implement the frame format: command byte, 16 key bytes, then 16 text bytes; within each field the first byte maps to bits [127:120].
REQ-004 SHALL decode commands as follows:
- 0x45 'E' selects encrypt (o_AesDec=0).
- 0x44 'D' selects decrypt (o_AesDec=1).
- Any other byte in IDLE is discarded and pulses o_fErr for 1 cycle.
REQ-005 SHALL use the states IDLE, RXKEY, RXTXT, START, WAIT, TXBYTE and TXGAP.
REQ-006 SHALL move IDLE->RXKEY on a valid command, RXKEY->RXTXT after the 16th key byte, and RXTXT->START after the 16th text byte, using a 4-bit byte counter that wraps 15->0.
REQ-007 SHALL hold o_AesStart=1 for exactly 1 cycle in START, then enter WAIT.
REQ-008 SHALL hold o_AesKey, o_AesText and o_AesDec stable from START until return to IDLE.
REQ-009 SHALL, in WAIT, capture i_AesText on the cycle i_AesDone=1 and enter TXBYTE; WAIT has no timeout.
REQ-010 SHALL, in TXBYTE with i_TxBusy=0, drive o_TxData with the next result byte (MSB byte first), pulse o_TxStart for 1 cycle, and enter TXGAP.
REQ-011 SHALL spend exactly 1 cycle in TXGAP, then return to TXBYTE, or to IDLE after the 16th byte.
REQ-012 SHALL silently ignore i_RxValid in START, WAIT, TXBYTE and TXGAP.
REQ-013 SHALL enforce an inter-byte timeout in RXKEY/RXTXT:
- The timeout counter clears on every accepted byte and on entry to RXKEY.
- When the counter reaches TIMEOUT_CYC-1 with no byte, the block returns to IDLE and pulses o_fErr.
- If i_RxValid coincides with expiry, the byte is accepted and no timeout occurs.
REQ-014 SHALL ignore i_AesDone outside WAIT.
REQ-015 SHALL never assert o_TxStart while i_TxBusy=1 is sampled in TXBYTE.

Reset
REQ-016 SHALL, while i_Rst=0 at a clock edge, enter IDLE and clear all internal registers, regardless of the current state.
REQ-017 SHALL hold these outputs at 0 during and after reset until next driven: o_TxStart, o_AesStart, o_AesDec, o_fErr, o_Busy, o_TxData, o_AesKey, o_AesText.

Configuration
REQ-018 SHALL, with AES_FRAME_KEY_CACHE_EN defined, accept 0x65 'e' and 0x64 'd' as encrypt/decrypt commands that skip RXKEY (command goes directly to RXTXT) and reuse the last loaded key. Reset clears the cached key to 0.
REQ-019 SHALL, without AES_FRAME_KEY_CACHE_EN, treat 0x65 and 0x64 as invalid commands per REQ-004.

Structure
REQ-020 SHALL place the following in package aes_frame_pkg:
- state encoding
- command byte constants (0x45, 0x44, 0x65, 0x64)
- FRAME_BYTES=16
REQ-021 SHALL implement the result byte serializer (capture register, byte index, TXBYTE/TXGAP pacing) as sub-module aes_frame_txser.

Verification
REQ-022 SHALL cover these directed scenarios:
- Encrypt: 'E', key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff -> one o_AesStart pulse; TX bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in order.
- Decrypt: 'D', same key, text 69c4e0d86a7b0430d8cdb78070b4c55a -> TX 00 11 22 ... ff.
- Invalid command: byte 0x41 in IDLE -> o_fErr pulse of 1 cycle, state stays IDLE, o_Busy=0.
- Timeout: TIMEOUT_CYC=100, stop after 5 key bytes -> o_fErr pulse at the 100th idle cycle, then IDLE; a following full 'E' frame completes correctly.
- TX backpressure: i_TxBusy held high 50 cycles after each o_TxStart -> no o_TxStart while busy, 16 bytes delivered, no loss.
- Reset mid-WAIT: i_Rst=0 for 1 cycle -> IDLE, all outputs 0, and a late i_AesDone is ignored. With AES_FRAME_KEY_CACHE_EN, 'e' plus 16 text bytes after an 'E' frame -> the same key is used and the same ciphertext is produced.
